sprite_scanner: RTL and testbench

SPRITE_SCANNER -- requirements
Module: sprite_scanner

---
 rtl/sprite_scanner_pkg.sv | 35 +++
 rtl/sprite_hit_check.sv | 35 +++
 rtl/sprite_scanner.sv | 129 ++++++++++++
 tb/tb_sprite_scanner.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_scanner_pkg.sv
// Shared types and constants for the per-line sprite scanner: FSM encoding,
// sprite word field positions and default raster geometry.
package sprite_scanner_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCheck,
    StArmed,
    StActive,
    StDone
  } state_e;

  // Sprite word layout: [29] enable, [28:19] x, [18:9] y, [8:0] memory offset.
  localparam int unsigned SprEnBit  = 29;
  localparam int unsigned SprXMsb   = 28;
  localparam int unsigned SprXLsb   = 19;
  localparam int unsigned SprYMsb   = 18;
  localparam int unsigned SprYLsb   = 9;
  localparam int unsigned SprOffMsb = 8;
  localparam int unsigned SprOffLsb = 0;

  localparam int unsigned SpriteSize = 20;
  localparam int unsigned HActive    = 640;
  localparam int unsigned VActive    = 480;

  function automatic logic [9:0] spr_x(input logic [31:0] word);
    return word[SprXMsb:SprXLsb];
  endfunction

  function automatic logic [9:0] spr_y(input logic [31:0] word);
    return word[SprYMsb:SprYLsb];
  endfunction

endpackage

// File: rtl/sprite_hit_check.sv
// Combinational test of one sprite word against the current raster position:
// vertical coverage (hit) and whether it can still be drawn whole (accept).
module sprite_hit_check
  import sprite_scanner_pkg::*;
#(
  parameter int unsigned SPRITE_SIZE = SpriteSize
) (
  input  logic [31:0] reg_data,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [10:0] prev_end,
  output logic        hit,
  output logic        accept
);

  logic [10:0] spr_x11;
  logic [10:0] spr_y11;
  logic [10:0] spr_y_end;
  logic [10:0] px11;
  logic [10:0] py11;
  logic        unused_fields;

  // 11-bit arithmetic so y + SPRITE_SIZE never wraps near the bottom edge.
  assign spr_x11   = {1'b0, spr_x(reg_data)};
  assign spr_y11   = {1'b0, spr_y(reg_data)};
  assign spr_y_end = spr_y11 + 11'(SPRITE_SIZE);
  assign px11      = {1'b0, pixel_x};
  assign py11      = {1'b0, pixel_y};

  assign hit    = reg_data[SprEnBit] && (py11 >= spr_y11) && (py11 < spr_y_end);
  assign accept = hit && (spr_x11 > px11) && (spr_x11 >= prev_end);

  assign unused_fields = ^{reg_data[31:30], reg_data[SprOffMsb:SprOffLsb]};

endmodule

// File: rtl/sprite_scanner.sv
// Per-line sprite scanner: walks the sprite register file in index order and
// hands one whole, non-overlapping sprite at a time to the drawing stage.
module sprite_scanner
  import sprite_scanner_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 32,
  parameter int unsigned SPRITE_SIZE = SpriteSize,
  parameter int unsigned H_ACTIVE    = HActive,
  parameter int unsigned V_ACTIVE    = VActive,
  localparam int unsigned IdxW       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic            clk_pixel,
  input  logic            reset,
  input  logic [9:0]      pixel_x,
  input  logic [9:0]      pixel_y,
  output logic [IdxW-1:0] reg_address,
  input  logic [31:0]     reg_data,
  input  logic            counter_finished,
  output logic [31:0]     sprite_datas,
  output logic            sprite_on,
  output logic [5:0]      line_count
);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   index_q, index_d;
  logic [10:0]       prev_end_q, prev_end_d;
  logic [31:0]       sprite_datas_q, sprite_datas_d;
  logic [5:0]        line_count_q, line_count_d;

  logic line_start;
  logic line_end;
  logic busy;
  logic last_idx;
  logic cand_accept;
  logic unused_hit;

  assign line_start = (pixel_x == '0) && ({1'b0, pixel_y} < 11'(V_ACTIVE));
  assign line_end   = (pixel_x == 10'(H_ACTIVE - 1));
  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign last_idx   = (index_q == IdxW'(NUM_SPRITES - 1));

  // accept already includes hit; hit is only exposed by the checker.
  sprite_hit_check #(
    .SPRITE_SIZE(SPRITE_SIZE)
  ) u_hit_check (
    .reg_data(reg_data),
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .prev_end(prev_end_q),
    .hit     (unused_hit),
    .accept  (cand_accept)
  );

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    prev_end_d     = prev_end_q;
    sprite_datas_d = sprite_datas_q;
    line_count_d   = line_count_q;
    sprite_on      = (state_q == StActive);

    if (line_start) begin
      state_d      = StFetch;
      index_d      = '0;
      prev_end_d   = '0;
      line_count_d = '0;
    end else if (line_end && busy) begin
      state_d = StDone;
    end else begin
      unique case (state_q)
        StFetch: state_d = StCheck;
        StCheck: begin
          if (cand_accept) begin
            sprite_datas_d = reg_data;
            prev_end_d     = {1'b0, spr_x(reg_data)} + 11'(SPRITE_SIZE);
            state_d        = StArmed;
          end else if (last_idx) begin
            state_d = StDone;
          end else begin
            index_d = index_q + IdxW'(1);
            state_d = StFetch;
          end
        end
        StArmed: begin
          // Raise sprite_on in the very cycle the beam reaches the sprite.
          if (pixel_x == spr_x(sprite_datas_q)) begin
            sprite_on = 1'b1;
            state_d   = StActive;
          end
        end
        StActive: begin
          if (counter_finished) begin
            if (line_count_q != 6'd63) begin
              line_count_d = line_count_q + 6'd1;
            end
            if (last_idx) begin
              state_d = StDone;
            end else begin
              index_d = index_q + IdxW'(1);
              state_d = StFetch;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q        <= StIdle;
      index_q        <= '0;
      prev_end_q     <= '0;
      sprite_datas_q <= '0;
      line_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      prev_end_q     <= prev_end_d;
      sprite_datas_q <= sprite_datas_d;
      line_count_q   <= line_count_d;
    end
  end

  assign reg_address  = index_q;
  assign sprite_datas = sprite_datas_q;
  assign line_count   = line_count_q;

endmodule

// File: tb/tb_sprite_scanner.sv
// Scoreboard bench for sprite_scanner: expected sprite launches are queued per
// line and matched against each rising edge of sprite_on.
module tb_sprite_scanner;

  localparam int NumSprites = 32;
  localparam int HActiveTb  = 640;
  localparam int HTotal     = 660;

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [4:0]  reg_address;
  logic [31:0] reg_data;
  logic        counter_finished;
  logic [31:0] sprite_datas;
  logic        sprite_on;
  logic [5:0]  line_count;

  logic [31:0] regs [NumSprites];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_word_q[$];
  logic [9:0]  exp_x_q[$];

  sprite_scanner dut (
    .clk_pixel       (clk_pixel),
    .reset           (reset),
    .pixel_x         (pixel_x),
    .pixel_y         (pixel_y),
    .reg_address     (reg_address),
    .reg_data        (reg_data),
    .counter_finished(counter_finished),
    .sprite_datas    (sprite_datas),
    .sprite_on       (sprite_on),
    .line_count      (line_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Register file with one-cycle synchronous read.
  always @(posedge clk_pixel) reg_data <= regs[reg_address];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] spr(input logic en, input int x, input int y, input int off);
    return {2'b00, en, x[9:0], y[9:0], off[8:0]};
  endfunction

  task automatic clear_regs();
    for (int i = 0; i < NumSprites; i++) regs[i] = '0;
  endtask

  task automatic expect_sprite(input logic [31:0] word);
    exp_word_q.push_back(word);
    exp_x_q.push_back(word[28:19]);
  endtask

  // One full raster line. cf_after > 0: pulse counter_finished once sprite_on
  // has been seen for cf_after cycles; 0 withholds it.
  task automatic run_line(input int y, input int cf_after, input int exp_count,
                          input bit hold_to_end);
    int on_cnt;
    bit prev_on;
    bit drop_pending;
    on_cnt = 0;
    prev_on = 1'b0;
    drop_pending = 1'b0;
    for (int p = 0; p < HTotal; p++) begin
      @(posedge clk_pixel);
      #1;
      pixel_x = 10'(p);
      pixel_y = 10'(y);
      counter_finished = (cf_after > 0) && (on_cnt == cf_after);
      @(negedge clk_pixel);
      if (drop_pending) begin
        check_eq("drop_after_finish", 32'(sprite_on), 32'd0);
        drop_pending = 1'b0;
      end
      if (counter_finished) drop_pending = 1'b1;
      if (sprite_on && !prev_on) begin
        check_eq("rise_expected", 32'(exp_word_q.size() != 0), 32'd1);
        if (exp_word_q.size() != 0) begin
          check_eq("rise_x", 32'(pixel_x), 32'(exp_x_q.pop_front()));
          check_eq("rise_word", sprite_datas, exp_word_q.pop_front());
        end
      end
      if (hold_to_end && p == HActiveTb - 1) check_eq("held_to_line_end", 32'(sprite_on), 32'd1);
      if (p == HActiveTb) check_eq("off_after_line_end", 32'(sprite_on), 32'd0);
      prev_on = sprite_on;
      on_cnt  = sprite_on ? on_cnt + 1 : 0;
    end
    counter_finished = 1'b0;
    check_eq("line_count", 32'(line_count), 32'(exp_count));
    check_eq("pending_sprites", 32'(exp_word_q.size()), 32'd0);
    exp_word_q.delete();
    exp_x_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int  px;
    int  on_seen;
    bit  found;
    logic [31:0] w0, w1, w2;

    clear_regs();
    reset = 1'b1;
    pixel_x = 10'd650;
    pixel_y = 10'd500;
    counter_finished = 1'b0;
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check_eq("reset_sprite_on", 32'(sprite_on), 32'd0);
    check_eq("reset_sprite_datas", sprite_datas, 32'd0);
    check_eq("reset_reg_address", 32'(reg_address), 32'd0);
    check_eq("reset_line_count", 32'(line_count), 32'd0);
    @(posedge clk_pixel);
    #1 reset = 1'b0;

    // Single sprite, drawn at x=100, dropped one cycle after counter_finished.
    w0 = spr(1'b1, 100, 50, 3);
    regs[0] = w0;
    expect_sprite(w0);
    run_line(55, 2, 1, 1'b0);

    // Disabled sprite 0 skipped; sprite 1 covers lines 10..29 only.
    clear_regs();
    w1 = spr(1'b1, 200, 10, 5);
    regs[0] = spr(1'b0, 50, 10, 1);
    regs[1] = w1;
    expect_sprite(w1);
    run_line(29, 2, 1, 1'b0);
    run_line(30, 2, 0, 1'b0);

    // Overlap: sprite 1 starts inside sprite 0 and is skipped.
    clear_regs();
    w0 = spr(1'b1, 100, 50, 0);
    w1 = spr(1'b1, 110, 50, 1);
    w2 = spr(1'b1, 120, 50, 2);
    regs[0] = w0;
    regs[1] = w1;
    regs[2] = w2;
    expect_sprite(w0);
    expect_sprite(w2);
    run_line(55, 2, 2, 1'b0);

    // Sprite at x=0 is already behind the beam when checked.
    clear_regs();
    regs[0] = spr(1'b1, 0, 0, 7);
    run_line(0, 2, 0, 1'b0);

    // counter_finished withheld: line end forces the sprite off; next line restarts.
    clear_regs();
    w0 = spr(1'b1, 600, 50, 1);
    regs[0] = w0;
    expect_sprite(w0);
    run_line(55, 0, 0, 1'b1);
    expect_sprite(w0);
    run_line(56, 2, 1, 1'b0);

    // Reset while a sprite is being drawn.
    clear_regs();
    w0 = spr(1'b1, 100, 50, 3);
    regs[0] = w0;
    found = 1'b0;
    px = 0;
    while (px < HTotal && !found) begin
      @(posedge clk_pixel);
      #1;
      pixel_x = 10'(px);
      pixel_y = 10'd55;
      @(negedge clk_pixel);
      if (sprite_on) found = 1'b1;
      px++;
    end
    check_eq("reset_seq_sprite_seen", 32'(found), 32'd1);
    @(posedge clk_pixel);
    #1;
    reset = 1'b1;
    pixel_x = 10'(px);
    px++;
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    pixel_x = 10'(px);
    px++;
    @(negedge clk_pixel);
    check_eq("midline_reset_sprite_on", 32'(sprite_on), 32'd0);
    check_eq("midline_reset_sprite_datas", sprite_datas, 32'd0);
    check_eq("midline_reset_reg_address", 32'(reg_address), 32'd0);
    on_seen = 0;
    while (px < HTotal) begin
      @(posedge clk_pixel);
      #1;
      pixel_x = 10'(px);
      @(negedge clk_pixel);
      if (sprite_on) on_seen++;
      px++;
    end
    check_eq("idle_until_line_start", 32'(on_seen), 32'd0);
    expect_sprite(w0);
    run_line(55, 3, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
